mips_exec_unit: RTL and testbench
=================================

Name: mips_exec_unit

Overview:
- Parametrised successor to the single-issue MIPS32 decode/execute stage.
- Accepts one instruction word per DIR/ack handshake and decodes R-type and I-type ALU instructions.
- Reads the register file, executes, writes back, then presents the result downstream with a DOR/ack handshake.
- Adds over the previous generation:
  - register array with configurable data width and register count;
  - I-type immediates;
  - variable shifts and unsigned compares;
  - overflow and reserved-instruction exception reporting.

Parameters:
- XLEN, 32, datapath and register width; legal values are 32 and 64.
- NREGS, 32, number of implemented GPRs (8..32); index 0 is hard-wired zero.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- DIR  input  1  upstream instruction valid.
- ack_prev  output  1  one-cycle pulse: instruction accepted.
- data_in  input  32  instruction word.
- DOR  output  1  result valid.
- ack_from_next  input  1  downstream accepted the result.
- data_out  output  XLEN  result value.
- exc  output  2  exception code: 0 none, 1 overflow, 2 reserved instruction; valid while DOR=1.

Behaviour:
- Reset:
  - state goes to IDLE.
  - DOR=0, ack_prev=0, data_out=0, exc=0.
  - All GPRs cleared to 0.
  - Reset in any state aborts the instruction in flight with no writeback.
- IDLE:
  - DIR=1 at an edge: latch data_in, set ack_prev=1 for exactly one cycle, go to FETCH.
- FETCH:
  - S <= GPR[rs = instr[25:21]], T <= GPR[rt = instr[20:16]].
  - Index 0, or any index >= NREGS, reads 0.
  - Go to EXEC.
- EXEC:
  - Compute D and exception code; go to WB.
- WB:
  - If exc=0 and destination index is non-zero and < NREGS, write GPR[dest] <= D; otherwise no write.
  - data_out <= D (0 for reserved instruction); DOR <= 1; go to WAIT_ACK.
- WAIT_ACK:
  - Hold DOR, data_out and exc stable until ack_from_next=1; then DOR <= 0 and go to IDLE.
- Latency: DIR sampled at edge N gives DOR=1 after edge N+3. Throughput is at most one instruction per 5 cycles.
- Handshake corner cases:
  - DIR is ignored outside IDLE; ack_prev stays 0.
  - ack_from_next is ignored outside WAIT_ACK.
  - ack_from_next and DIR both high in WAIT_ACK: only the return to IDLE happens; DIR is sampled on the next edge.
- R-type (opcode instr[31:26]=0), destination rd=instr[15:11], shamt=instr[10:6]:
  - funct 00 sll, 02 srl (logical), 03 sra (arithmetic).
  - funct 04 sllv, 06 srlv, 07 srav: shift amount S[log2(XLEN)-1:0].
  - funct 20 add, 22 sub: signed overflow -> exc=1.
  - funct 21 addu, 23 subu.
  - funct 24 and, 25 or, 26 xor, 27 nor.
  - funct 2A slt (signed), 2B sltu (unsigned).
  - Other funct -> exc=2.
- I-type, destination rt, imm=instr[15:0]:
  - 08 addi: signed overflow -> exc=1.
  - 09 addiu.
  - 0A slti, 0B sltiu: sign-extended imm, compare signed / unsigned respectively.
  - 0C andi, 0D ori, 0E xori: zero-extended imm.
  - 0F lui: D = sign-extend(imm<<16).
  - Other opcodes -> exc=2.
- Arithmetic: results wrap modulo 2^XLEN. Overflow is detected when operand signs match and the result sign differs (inverted operand for sub).

Optional Feature:
- Macro: MIPS_EXEC_DEBUG_PORT_EN.
- Defined: adds ports dbg_addr (input, 5) and dbg_data (output, XLEN).
  - dbg_data is a combinational read of GPR[dbg_addr]; index 0 or >= NREGS reads 0.
  - Has no effect on the FSM.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- addi 0x20080005, addi 0x2009FFFD, then add 0x01095020 -> data_out 5, 0xFFFFFFFD, 2; exc=0; $t2=2.
- lui 0x3C087FFF, ori 0x3508FFFF, addi 0x21090001 -> third result exc=1, data_out 0x80000000, $t1 unchanged.
- With $t1=-3 and $t0=5: slt 0x0128582A -> 1; sltu 0x0128582B -> 0; sra 0x00096043 -> 0xFFFFFFFE.
- 0xFC000000 -> exc=2, data_out 0; addi 0x20000007 -> data_out 7, then add 0x00006820 -> 0 ($0 not written).
- Back-pressure:
  - hold ack_from_next=0 for 10 cycles with DIR=1 -> DOR stays 1, data_out stable, ack_prev stays 0;
  - on ack: DOR=0 one cycle later, next instruction accepted the edge after.
- Assert reset in EXEC of addi 0x20080009 -> outputs return to 0, $t0 stays 0, next DIR accepted normally.

Source files
------------

// File: rtl/mips_exec_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mips_exec_unit: MIPS32 R/I-type ALU decode/execute stage with a GPR file,  |
// | DIR/ack instruction intake and DOR/ack result delivery.                    |
// | Optional debug read port: define MIPS_EXEC_DEBUG_PORT_EN.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mips_exec_unit #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            DIR,
  output logic            ack_prev,
  input  logic [31:0]     data_in,
  output logic            DOR,
  input  logic            ack_from_next,
  output logic [XLEN-1:0] data_out,
  output logic [1:0]      exc
`ifdef MIPS_EXEC_DEBUG_PORT_EN
  ,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
`endif
);

  localparam int         c_shw      = $clog2(XLEN);
  localparam logic [1:0] c_exc_none = 2'd0;
  localparam logic [1:0] c_exc_ovf  = 2'd1;
  localparam logic [1:0] c_exc_ri   = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_EXEC     = 3'd2,
    S_WB       = 3'd3,
    S_WAIT_ACK = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] s_q, s_d, t_q, t_d, d_q, d_d;
  logic [XLEN-1:0] data_out_q, data_out_d;
  logic [1:0]      ecode_q, ecode_d, exc_q, exc_d;
  logic            ack_prev_q, ack_prev_d, dor_q, dor_d;
  logic [XLEN-1:0] gpr_q [NREGS];
  logic [XLEN-1:0] gpr_d [NREGS];
  logic            w_we;

  // Index 0 and unimplemented indices read as zero.
  function automatic logic [XLEN-1:0] rd_gpr(input logic [4:0] idx);
    logic [XLEN-1:0] val;
    val = '0;
    for (int i = 1; i < NREGS; i++)
      if (idx == 5'(i)) val = gpr_q[i];
    return val;
  endfunction

  logic [5:0]       w_opcode, w_funct;
  logic [4:0]       w_rs, w_rt, w_rd, w_shamt, w_dest;
  logic [15:0]      w_imm;
  logic [XLEN-1:0]  w_simm, w_zimm, w_sum, w_diff, w_isum, w_alu;
  logic [c_shw-1:0] w_vsh;
  logic             w_add_ovf, w_sub_ovf, w_addi_ovf;
  logic [1:0]       w_ecode;

  assign w_opcode = instr_q[31:26];
  assign w_rs     = instr_q[25:21];
  assign w_rt     = instr_q[20:16];
  assign w_rd     = instr_q[15:11];
  assign w_shamt  = instr_q[10:6];
  assign w_funct  = instr_q[5:0];
  assign w_imm    = instr_q[15:0];
  assign w_dest   = (w_opcode == 6'h00) ? w_rd : w_rt;

  assign w_simm = {{(XLEN-16){w_imm[15]}}, w_imm};
  assign w_zimm = {{(XLEN-16){1'b0}}, w_imm};
  assign w_sum  = s_q + t_q;
  assign w_diff = s_q - t_q;
  assign w_isum = s_q + w_simm;
  assign w_vsh  = s_q[c_shw-1:0];

  // Signed overflow: operands agree in sign but the result does not.
  assign w_add_ovf  = (s_q[XLEN-1] == t_q[XLEN-1])    && (w_sum[XLEN-1]  != s_q[XLEN-1]);
  assign w_sub_ovf  = (s_q[XLEN-1] != t_q[XLEN-1])    && (w_diff[XLEN-1] != s_q[XLEN-1]);
  assign w_addi_ovf = (s_q[XLEN-1] == w_simm[XLEN-1]) && (w_isum[XLEN-1] != s_q[XLEN-1]);

  always_comb begin
    w_alu   = '0;
    w_ecode = c_exc_none;
    if (w_opcode == 6'h00) begin
      case (w_funct)
        6'h00: w_alu = t_q << w_shamt;
        6'h02: w_alu = t_q >> w_shamt;
        6'h03: w_alu = $signed(t_q) >>> w_shamt;
        6'h04: w_alu = t_q << w_vsh;
        6'h06: w_alu = t_q >> w_vsh;
        6'h07: w_alu = $signed(t_q) >>> w_vsh;
        6'h20: begin
          w_alu = w_sum;
          if (w_add_ovf) w_ecode = c_exc_ovf;
        end
        6'h21: w_alu = w_sum;
        6'h22: begin
          w_alu = w_diff;
          if (w_sub_ovf) w_ecode = c_exc_ovf;
        end
        6'h23: w_alu = w_diff;
        6'h24: w_alu = s_q & t_q;
        6'h25: w_alu = s_q | t_q;
        6'h26: w_alu = s_q ^ t_q;
        6'h27: w_alu = ~(s_q | t_q);
        6'h2A: w_alu = {{(XLEN-1){1'b0}}, $signed(s_q) < $signed(t_q)};
        6'h2B: w_alu = {{(XLEN-1){1'b0}}, s_q < t_q};
        default: w_ecode = c_exc_ri;
      endcase
    end else begin
      case (w_opcode)
        6'h08: begin
          w_alu = w_isum;
          if (w_addi_ovf) w_ecode = c_exc_ovf;
        end
        6'h09: w_alu = w_isum;
        6'h0A: w_alu = {{(XLEN-1){1'b0}}, $signed(s_q) < $signed(w_simm)};
        6'h0B: w_alu = {{(XLEN-1){1'b0}}, s_q < w_simm};
        6'h0C: w_alu = s_q & w_zimm;
        6'h0D: w_alu = s_q | w_zimm;
        6'h0E: w_alu = s_q ^ w_zimm;
        6'h0F: w_alu = w_simm << 16;
        default: w_ecode = c_exc_ri;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    s_d        = s_q;
    t_d        = t_q;
    d_d        = d_q;
    ecode_d    = ecode_q;
    ack_prev_d = 1'b0;
    dor_d      = dor_q;
    data_out_d = data_out_q;
    exc_d      = exc_q;
    w_we       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (DIR) begin
          instr_d    = data_in;
          ack_prev_d = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        s_d     = rd_gpr(w_rs);
        t_d     = rd_gpr(w_rt);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        d_d     = w_alu;
        ecode_d = w_ecode;
        state_d = S_WB;
      end
      S_WB: begin
        w_we       = (ecode_q == c_exc_none) && (w_dest != 5'd0);
        data_out_d = (ecode_q == c_exc_ri) ? '0 : d_q;
        exc_d      = ecode_q;
        dor_d      = 1'b1;
        state_d    = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (ack_from_next) begin
          dor_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Destinations outside the implemented range simply match no register.
  always_comb begin
    gpr_d = gpr_q;
    for (int i = 1; i < NREGS; i++)
      if (w_we && (w_dest == 5'(i))) gpr_d[i] = d_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      s_q        <= '0;
      t_q        <= '0;
      d_q        <= '0;
      ecode_q    <= c_exc_none;
      ack_prev_q <= 1'b0;
      dor_q      <= 1'b0;
      data_out_q <= '0;
      exc_q      <= c_exc_none;
      for (int i = 0; i < NREGS; i++) gpr_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      s_q        <= s_d;
      t_q        <= t_d;
      d_q        <= d_d;
      ecode_q    <= ecode_d;
      ack_prev_q <= ack_prev_d;
      dor_q      <= dor_d;
      data_out_q <= data_out_d;
      exc_q      <= exc_d;
      gpr_q      <= gpr_d;
    end
  end

  assign ack_prev = ack_prev_q;
  assign DOR      = dor_q;
  assign data_out = data_out_q;
  assign exc      = exc_q;

`ifdef MIPS_EXEC_DEBUG_PORT_EN
  assign dbg_data = rd_gpr(dbg_addr);
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_exec_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mips_exec_unit: scoreboard bench for mips_exec_unit with a behavioural   |
// | instruction model, directed scenarios and randomized instruction streams.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mips_exec_unit;

  localparam int XLEN = 32;

  logic            clk           = 1'b0;
  logic            reset         = 1'b1;
  logic            DIR           = 1'b0;
  logic [31:0]     data_in       = '0;
  logic            ack_from_next = 1'b0;
  logic            ack_prev;
  logic            DOR;
  logic [XLEN-1:0] data_out;
  logic [1:0]      exc;
`ifdef MIPS_EXEC_DEBUG_PORT_EN
  logic [4:0]      dbg_addr = '0;
  logic [XLEN-1:0] dbg_data;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  exc;
  } exp_t;

  int          checks   = 0;
  int          failures = 0;
  exp_t        exp_q[$];
  exp_t        cur_exp;
  logic [31:0] mregs [32];
  bit          hold_ack  = 1'b0;
  bit          force_ack = 1'b0;
  logic        prev_dor  = 1'b0;
  logic        prev_ack  = 1'b0;

  mips_exec_unit #(.XLEN(XLEN), .NREGS(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .DIR           (DIR),
    .ack_prev      (ack_prev),
    .data_in       (data_in),
    .DOR           (DOR),
    .ack_from_next (ack_from_next),
    .data_out      (data_out),
    .exc           (exc)
`ifdef MIPS_EXEC_DEBUG_PORT_EN
    ,
    .dbg_addr      (dbg_addr),
    .dbg_data      (dbg_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] sra_ref(input logic [31:0] v, input int sh);
    logic [31:0] r;
    r = v;
    for (int i = 0; i < sh; i++) r = {r[31], r[31:1]};
    return r;
  endfunction

  // Reference: signed arithmetic done in 64-bit integers, overflow = result out of 32-bit range.
  function automatic exp_t model(input logic [31:0] ins);
    logic [5:0]  op;
    logic [4:0]  dst;
    logic [31:0] s, t, d, zimm;
    logic [1:0]  e;
    longint      ss, st, si, r;
    exp_t        x;
    op   = ins[31:26];
    s    = mregs[ins[25:21]];
    t    = mregs[ins[20:16]];
    ss   = longint'($signed(s));
    st   = longint'($signed(t));
    si   = longint'($signed(ins[15:0]));
    zimm = {16'h0000, ins[15:0]};
    d    = '0;
    e    = 2'd0;
    r    = 0;
    if (op == 6'h00) begin
      dst = ins[15:11];
      case (ins[5:0])
        6'h00: d = t << ins[10:6];
        6'h02: d = t >> ins[10:6];
        6'h03: d = sra_ref(t, int'(ins[10:6]));
        6'h04: d = t << s[4:0];
        6'h06: d = t >> s[4:0];
        6'h07: d = sra_ref(t, int'(s[4:0]));
        6'h20, 6'h21: begin
          r = ss + st;
          d = r[31:0];
          if (ins[5:0] == 6'h20 && (r > 64'sd2147483647 || r < -64'sd2147483648)) e = 2'd1;
        end
        6'h22, 6'h23: begin
          r = ss - st;
          d = r[31:0];
          if (ins[5:0] == 6'h22 && (r > 64'sd2147483647 || r < -64'sd2147483648)) e = 2'd1;
        end
        6'h24: d = s & t;
        6'h25: d = s | t;
        6'h26: d = s ^ t;
        6'h27: d = ~(s | t);
        6'h2A: d = (ss < st) ? 32'd1 : 32'd0;
        6'h2B: d = (s < t) ? 32'd1 : 32'd0;
        default: e = 2'd2;
      endcase
    end else begin
      dst = ins[20:16];
      case (op)
        6'h08, 6'h09: begin
          r = ss + si;
          d = r[31:0];
          if (op == 6'h08 && (r > 64'sd2147483647 || r < -64'sd2147483648)) e = 2'd1;
        end
        6'h0A: d = (ss < si) ? 32'd1 : 32'd0;
        6'h0B: begin
          r = si;
          d = (s < r[31:0]) ? 32'd1 : 32'd0;
        end
        6'h0C: d = s & zimm;
        6'h0D: d = s | zimm;
        6'h0E: d = s ^ zimm;
        6'h0F: d = {ins[15:0], 16'h0000};
        default: e = 2'd2;
      endcase
    end
    if (e == 2'd2) d = '0;
    if (e == 2'd0 && dst != 5'd0) mregs[dst] = d;
    x.data = d;
    x.exc  = e;
    return x;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] f, op;
    logic [4:0] rs, rt, rd, sh;
    rs = 5'($urandom_range(0, 15));
    rt = 5'($urandom_range(0, 15));
    rd = 5'($urandom_range(0, 15));
    sh = 5'($urandom_range(0, 31));
    if ($urandom_range(0, 1) == 0) begin
      case ($urandom_range(0, 16))
        0: f = 6'h00;  1: f = 6'h02;  2: f = 6'h03;  3: f = 6'h04;
        4: f = 6'h06;  5: f = 6'h07;  6: f = 6'h20;  7: f = 6'h21;
        8: f = 6'h22;  9: f = 6'h23; 10: f = 6'h24; 11: f = 6'h25;
        12: f = 6'h26; 13: f = 6'h27; 14: f = 6'h2A; 15: f = 6'h2B;
        default: f = 6'h01;
      endcase
      return {6'h00, rs, rt, rd, sh, f};
    end
    op = 6'($urandom_range(8, 16));
    return {op, rs, rt, 16'($urandom)};
  endfunction

  // Hold DIR until accepted, then record the expected response.
  task automatic issue(input logic [31:0] ins, input bit directed, input logic [31:0] ed,
                       input logic [1:0] ee, output int waited);
    exp_t m;
    data_in = ins;
    DIR     = 1'b1;
    waited  = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!ack_prev && waited < 60);
    DIR = 1'b0;
    if (!ack_prev) begin
      checks++;
      failures++;
      $display("FAIL accept timeout: instr %h not accepted", ins);
    end else begin
      m = model(ins);
      if (directed) begin
        m.data = ed;
        m.exc  = ee;
      end
      exp_q.push_back(m);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || DOR) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      failures++;
      $display("FAIL drain timeout: pending=%0d DOR=%0b", exp_q.size(), DOR);
    end
  endtask

  // Downstream consumer with random acceptance.
  always begin
    @(negedge clk);
    #1;
    ack_from_next = DOR && (force_ack || (!hold_ack && ($urandom_range(0, 2) == 0)));
  end

  // Result monitor and scoreboard.
  always @(negedge clk) begin
    if (ack_prev) check("ack_prev single pulse", 32'(prev_ack), 32'd0);
    if (DOR && !prev_dor) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected result: data_out=%h exc=%0d", data_out, exc);
      end else begin
        cur_exp = exp_q.pop_front();
        check("result data", data_out, cur_exp.data);
        check("result exc", 32'(exc), 32'(cur_exp.exc));
      end
    end else if (DOR) begin
      check("hold data", data_out, cur_exp.data);
      check("hold exc", 32'(exc), 32'(cur_exp.exc));
    end
    prev_dor <= DOR;
    prev_ack <= ack_prev;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, n;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset DOR", 32'(DOR), 32'd0);
    check("reset ack_prev", 32'(ack_prev), 32'd0);
    check("reset data_out", data_out, 32'd0);
    check("reset exc", 32'(exc), 32'd0);

    issue(32'h20080005, 1'b1, 32'h00000005, 2'd0, w);
    issue(32'h2009FFFD, 1'b1, 32'hFFFFFFFD, 2'd0, w);
    issue(32'h01095020, 1'b1, 32'h00000002, 2'd0, w);
    issue(32'h01401821, 1'b1, 32'h00000002, 2'd0, w);
    issue(32'h3C087FFF, 1'b1, 32'h7FFF0000, 2'd0, w);
    issue(32'h3508FFFF, 1'b1, 32'h7FFFFFFF, 2'd0, w);
    issue(32'h21090001, 1'b1, 32'h80000000, 2'd1, w);
    issue(32'h20080005, 1'b1, 32'h00000005, 2'd0, w);
    issue(32'h0128582A, 1'b1, 32'h00000001, 2'd0, w);
    issue(32'h0128582B, 1'b1, 32'h00000000, 2'd0, w);
    issue(32'h00096043, 1'b1, 32'hFFFFFFFE, 2'd0, w);
    issue(32'hFC000000, 1'b1, 32'h00000000, 2'd2, w);
    issue(32'h20000007, 1'b1, 32'h00000007, 2'd0, w);
    issue(32'h00006820, 1'b1, 32'h00000000, 2'd0, w);
    drain();

    // Back-pressure: result held while DIR stays asserted.
    hold_ack = 1'b1;
    issue(32'h01095826, 1'b1, 32'hFFFFFFF8, 2'd0, w);
    n = 0;
    while (!DOR && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("backpressure DOR rise", 32'(DOR), 32'd1);
    data_in = 32'h3C0A1234;
    DIR     = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("bp DOR held", 32'(DOR), 32'd1);
      check("bp data_out stable", data_out, 32'hFFFFFFF8);
      check("bp ack_prev low", 32'(ack_prev), 32'd0);
    end
    force_ack = 1'b1;
    @(negedge clk);
    check("bp DOR after ack", 32'(DOR), 32'd0);
    force_ack = 1'b0;
    hold_ack  = 1'b0;
    issue(32'h3C0A1234, 1'b1, 32'h12340000, 2'd0, w);
    check("bp accept latency", 32'(w), 32'd1);
    drain();

    // Reset while the instruction is in EXEC.
    data_in = 32'h20080009;
    DIR     = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack_prev && n < 60);
    DIR = 1'b0;
    check("reset-test accept", 32'(ack_prev), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    check("abort DOR", 32'(DOR), 32'd0);
    check("abort ack_prev", 32'(ack_prev), 32'd0);
    check("abort data_out", data_out, 32'd0);
    check("abort exc", 32'(exc), 32'd0);
    issue(32'h01001021, 1'b1, 32'h00000000, 2'd0, w);
    check("post-reset accept latency", 32'(w), 32'd1);
    drain();

    for (int k = 0; k < 120; k++) issue(rand_instr(), 1'b0, 32'h0, 2'd0, w);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
